// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard detection and IF/ID, ID/EX pipeline control (Mealy FSM: RUN/STALL2/HALT).
// Optional stall-cycle counter on StallCount when HAZARD_STALL_COUNT_EN is defined.
module id_hazard_ctrl #(
   parameter int REG_BITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [REG_BITS-1:0] IDRs,
   input  logic [REG_BITS-1:0] IDRt,
   input  logic                IDUsesRs,
   input  logic                IDUsesRt,
   input  logic                IDIsBranch,
   input  logic                IDHlt,
   input  logic                BranchTaken,
   input  logic [REG_BITS-1:0] EXRd,
   input  logic                EXRegWrite,
   input  logic                EXMemRead,
   input  logic [REG_BITS-1:0] MEMRd,
   input  logic                MEMMemRead,
   output logic                PCWriteEnable,
   output logic                IFIDWriteEnable,
   output logic                IFIDStall,
   output logic                IFIDNoop,
`ifdef HAZARD_STALL_COUNT_EN
   output logic                IDEXNoop,
   output logic [15:0]         StallCount
`else
   output logic                IDEXNoop
`endif
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      STALL2 = 2'd1,
      HALT   = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic rs_ex_hit;
   logic rt_ex_hit;
   logic rs_mem_hit;
   logic load_use;
   logic br_on_alu;
   logic br_on_mem_load;
   logic br_on_ex_load;
   logic one_stall;
   logic two_stall;
   logic stall_now;

   // R0 is hardwired zero, so it never carries a dependency.
   assign rs_ex_hit  = IDUsesRs && (EXRd  != '0) && (IDRs == EXRd);
   assign rt_ex_hit  = IDUsesRt && (EXRd  != '0) && (IDRt == EXRd);
   assign rs_mem_hit = IDUsesRs && (MEMRd != '0) && (IDRs == MEMRd);

   assign load_use       = EXMemRead && (rs_ex_hit || rt_ex_hit);
   assign br_on_alu      = IDIsBranch && EXRegWrite && !EXMemRead && rs_ex_hit;
   assign br_on_mem_load = IDIsBranch && MEMMemRead && rs_mem_hit;
   assign br_on_ex_load  = IDIsBranch && EXMemRead && rs_ex_hit;

   // A branch waiting on a load still in EX needs the load to reach WB-forwardable MEM first.
   assign two_stall = br_on_ex_load;
   assign one_stall = !two_stall && (load_use || br_on_alu || br_on_mem_load);

   assign stall_now = (state == STALL2) || ((state == RUN) && (one_stall || two_stall));

   always_comb begin
      PCWriteEnable   = 1'b0;
      IFIDWriteEnable = 1'b0;
      IFIDStall       = 1'b0;
      IFIDNoop        = 1'b0;
      IDEXNoop        = 1'b0;
      state_next      = state;
      if (!rst) begin
         case (state)
            RUN: begin
               if (two_stall) begin
                  IDEXNoop   = 1'b1;
                  IFIDStall  = 1'b1;
                  state_next = STALL2;
               end else if (one_stall) begin
                  IDEXNoop = 1'b1;
               end else if (BranchTaken) begin
                  PCWriteEnable   = 1'b1;
                  IFIDWriteEnable = 1'b1;
                  IFIDNoop        = 1'b1;
               end else if (IDHlt) begin
                  IFIDWriteEnable = 1'b1;
                  IFIDNoop        = 1'b1;
                  state_next      = HALT;
               end else begin
                  PCWriteEnable   = 1'b1;
                  IFIDWriteEnable = 1'b1;
               end
            end
            STALL2: begin
               IDEXNoop   = 1'b1;
               state_next = RUN;
            end
            HALT: begin
               IFIDWriteEnable = 1'b1;
               IFIDNoop        = 1'b1;
               state_next      = HALT;
            end
            default: begin
               state_next = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

`ifdef HAZARD_STALL_COUNT_EN
   // Saturating count of stall bubbles; flush and halt no-ops are excluded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         StallCount <= 16'd0;
      end else if (stall_now && (StallCount != 16'hFFFF)) begin
         StallCount <= StallCount + 16'd1;
      end
   end
`else
   logic unused_stall_now;
   assign unused_stall_now = stall_now;
`endif

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Hazard-detection and pipeline-control block for the decode stage. It generates the write-enable, stall-reassert and no-op controls consumed by the PC register, the IF/ID pipeline register and the ID/EX pipeline register. It detects load-use and branch-operand hazards and inserts one or two bubbles. It also flushes IF/ID on taken branches and freezes fetch after a halt. It sits beside the decoder in ID and is the sole driver of the IF/ID `WriteEnable`, `StallIn` and `NoopIn` inputs.

## Interface
Parameters:
- `REG_BITS`, 4, register-specifier width (16 architectural registers; R0 hardwired zero)

Ports:
- `clk` input 1: clock, rising edge
- `rst` input 1: reset, asynchronous, active-high
- `IDRs`, `IDRt` input REG_BITS: source specifiers of the instruction in ID
- `IDUsesRs`, `IDUsesRt` input 1: the ID instruction actually reads that source
- `IDIsBranch` input 1: ID instruction is a register-resolved branch (BR); its operand is on `IDRs`
- `IDHlt` input 1: ID instruction is HLT
- `BranchTaken` input 1: branch in ID resolved taken this cycle
- `EXRd` input REG_BITS, `EXRegWrite` input 1, `EXMemRead` input 1: destination info of the instruction in EX
- `MEMRd` input REG_BITS, `MEMMemRead` input 1: destination info of the instruction in MEM
- `PCWriteEnable` output 1: PC register write enable
- `IFIDWriteEnable` output 1: IF/ID write enable
- `IFIDStall` output 1: stall-reassert request to the IF/ID `StallIn` input
- `IFIDNoop` output 1: flush IF/ID
- `IDEXNoop` output 1: insert a bubble into ID/EX
- `StallCount` output 16: stall-cycle counter (present only with `HAZARD_STALL_COUNT_EN`)

## Operation
- Match rule: `X` hits a destination `D` only if `X == D`, `D != 0`, and the corresponding `IDUses*` input is 1.
- Load-use (1 stall): `EXMemRead` and a hit on `EXRd`, via `IDRs` or `IDRt`.
- Branch-on-ALU (1 stall): `IDIsBranch`, `EXRegWrite`, `!EXMemRead`, and an `IDRs` hit on `EXRd`.
- Branch-on-load in MEM (1 stall): `IDIsBranch`, `MEMMemRead`, and an `IDRs` hit on `MEMRd`.
- Branch-on-load in EX (2 stalls): `IDIsBranch`, `EXMemRead`, and an `IDRs` hit on `EXRd`.
- Stall cycle outputs: `PCWriteEnable=0`, `IFIDWriteEnable=0`, `IDEXNoop=1`, `IFIDNoop=0`.
- FSM states: RUN, STALL2, HALT.
- RUN, 2-stall hazard: stall outputs, `IFIDStall=1`, next state STALL2.
- RUN, 1-stall hazard: stall outputs, `IFIDStall=0`, stay in RUN.
- RUN, no hazard, `BranchTaken`: enables 1, `IFIDNoop=1`, `IDEXNoop=0`.
- RUN, no hazard, `IDHlt`: `PCWriteEnable=0`, `IFIDWriteEnable=1`, `IFIDNoop=1`, next state HALT.
- RUN, none of the above: enables 1, all no-ops 0, `IFIDStall=0`.
- STALL2: stall outputs unconditionally, `IFIDStall=0`, next state RUN. All hazard inputs and `BranchTaken` are ignored. The hazard is re-evaluated in RUN on the following cycle.
- HALT: `PCWriteEnable=0`, `IFIDWriteEnable=1`, `IFIDNoop=1`, `IDEXNoop=0`. Exit only through `rst`.
- Priority in RUN: hazard > `BranchTaken` > `IDHlt`. `BranchTaken` asserted together with a hazard is ignored, because the branch has not resolved.

## Timing
- Outputs are combinational from state and inputs (Mealy) and take effect at the same edge that commits the pipeline registers.
- State updates on the rising `clk` edge.
- While `rst=1`:
  - all outputs are 0 (`PCWriteEnable`, `IFIDWriteEnable`, `IFIDStall`, `IFIDNoop`, `IDEXNoop`);
  - state is RUN;
  - `StallCount` is 0.
- `rst` asserted mid-STALL2 or in HALT returns the block to RUN immediately (asynchronous). No residual stall follows deassertion.
- The first cycle after `rst` falls is RUN with inputs evaluated normally.
- Latency: a 1-stall hazard costs 1 cycle and a 2-stall hazard costs exactly 2 cycles.

## Configuration
- `HAZARD_STALL_COUNT_EN` defined:
  - `StallCount` exists as a 16-bit register.
  - It increments on every edge where `IDEXNoop=1` due to a stall, in RUN or STALL2.
  - Flush and HALT no-ops do not count.
  - It saturates at 0xFFFF, with no wrap.
- `HAZARD_STALL_COUNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Load-use: `IDRs=3`, `IDUsesRs=1`, `EXRd=3`, `EXMemRead=1` -> one cycle with `PCWriteEnable=0`, `IFIDWriteEnable=0`, `IDEXNoop=1`, `IFIDStall=0`. With the hazard inputs cleared, the next cycle has enables=1.
- Branch-on-load in EX: `IDIsBranch=1`, `IDRs=5`, `EXRd=5`, `EXMemRead=1`:
  - cycle 1: stall outputs with `IFIDStall=1`;
  - cycle 2 (STALL2): stall outputs;
  - cycle 3: RUN, enables=1.
  - With `HAZARD_STALL_COUNT_EN`, `StallCount` goes 0 -> 2.
- R0 / unused source: `IDRt=0`, `EXRd=0`, `EXMemRead=1`; and separately `IDRs=4`, `IDUsesRs=0`, `EXRd=4`, `EXMemRead=1` -> no stall in either case.
- Taken branch with no hazard: `BranchTaken=1` -> `IFIDNoop=1`, `PCWriteEnable=1`, `IDEXNoop=0`. `BranchTaken=1` together with a load-use hazard -> stall only, `IFIDNoop=0`.
- Halt: `IDHlt=1` -> `PCWriteEnable=0`, `IFIDNoop=1`. The outputs persist for 10+ cycles regardless of the hazard inputs, and `rst` pulse restores enables=1.
- Reset mid-STALL2: assert `rst` asynchronously between edges during STALL2 -> outputs go to 0 immediately. After deassertion, the first cycle with no hazard has enables=1 and `IDEXNoop=0`.
